// File: rtl/adder_hf_pkg.sv
// -----------------------------------------------------------------------------
// adder_hf_pkg
// Shared types and helpers for the registered 1-bit half adder.
//   CNT_W_DEFAULT : default width of the statistics counters
//   ha_result_t   : packed {sum, carry} pair produced by a half adder
//   ha_eval(a, b) : combinational half-adder evaluation
// -----------------------------------------------------------------------------
package adder_hf_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef struct packed {
        logic sum;
        logic carry;
    } ha_result_t;

    function automatic ha_result_t ha_eval(input logic a, input logic b);
        ha_result_t r;
        r.sum   = a ^ b;
        r.carry = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// -----------------------------------------------------------------------------
// half_adder_cell
// Purely combinational half adder.
// Ports:
//   a, b   : operand bits
//   sum    : a ^ b
//   carry  : a & b
// -----------------------------------------------------------------------------
module half_adder_cell
    import adder_hf_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    ha_result_t res;

    assign res   = ha_eval(a, b);
    assign sum   = res.sum;
    assign carry = res.carry;

endmodule

// File: rtl/adder_hf_1bit.sv
// -----------------------------------------------------------------------------
// adder_hf_1bit
// Registered 1-bit half adder with one-cycle latency, qualified by a valid
// strobe, plus optional saturating operation/carry statistics counters.
//
// Build option:
//   ADDER_HF_STATS_EN : when defined, op_count/carry_count are live counters
//                       cleared by clr_stats; when undefined they are tied to 0
//                       and clr_stats is ignored.
//
// Parameters:
//   CNT_W       : statistics counter width (2..32)
//
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   in_valid    : operands valid, accepted at the rising edge
//   in1, in2    : operand bits
//   out         : registered sum bit
//   carry       : registered carry bit
//   out_valid   : out/carry hold a fresh result this cycle
//   clr_stats   : synchronous clear of the statistics counters
//   op_count    : accepted operations (saturating)
//   carry_count : accepted operations with carry = 1 (saturating)
// -----------------------------------------------------------------------------
module adder_hf_1bit
    import adder_hf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in1,
    input  logic             in2,
    output logic             out,
    output logic             carry,
    output logic             out_valid,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] carry_count
);

    if (CNT_W < 2 || CNT_W > 32) begin : g_cnt_w_check
        $error("adder_hf_1bit: CNT_W must be in 2..32");
    end

    logic sum_p0;
    logic carry_p0;

    half_adder_cell u_cell (
        .a     (in1),
        .b     (in2),
        .sum   (sum_p0),
        .carry (carry_p0)
    );

    // ---- p0 -> p1 : result register ----
    logic sum_p1;
    logic carry_p1;
    logic vld_p1;

    // Result bits are only loaded on accept so they hold across idle cycles;
    // reset still clears them so the outputs come up at a known 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1   <= 1'b0;
            carry_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1   <= sum_p0;
                carry_p1 <= carry_p0;
            end
        end
    end

    assign out       = sum_p1;
    assign carry     = carry_p1;
    assign out_valid = vld_p1;

`ifdef ADDER_HF_STATS_EN

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] op_cnt_p1;
    logic [CNT_W-1:0] carry_cnt_p1;

    // Clear beats a same-cycle accept: the accepted operation is not counted.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            op_cnt_p1    <= '0;
            carry_cnt_p1 <= '0;
        end else if (in_valid) begin
            op_cnt_p1 <= sat_inc(op_cnt_p1);
            if (carry_p0) begin
                carry_cnt_p1 <= sat_inc(carry_cnt_p1);
            end
        end
    end

    assign op_count    = op_cnt_p1;
    assign carry_count = carry_cnt_p1;

`else

    logic unused_clr_stats;

    assign unused_clr_stats = clr_stats;
    assign op_count         = '0;
    assign carry_count      = '0;

`endif

endmodule

// File: tb/tb_adder_hf_1bit.sv
module tb_adder_hf_1bit;

`ifdef ADDER_HF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in1;
    logic        in2;
    logic        clr_stats;
    logic        out;
    logic        carry;
    logic        out_valid;
    logic [15:0] op_count;
    logic [15:0] carry_count;
    logic        s_out;
    logic        s_carry;
    logic        s_out_valid;
    logic [1:0]  s_op_count;
    logic [1:0]  s_carry_count;

    adder_hf_1bit #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in1         (in1),
        .in2         (in2),
        .out         (out),
        .carry       (carry),
        .out_valid   (out_valid),
        .clr_stats   (clr_stats),
        .op_count    (op_count),
        .carry_count (carry_count)
    );

    adder_hf_1bit #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in1         (in1),
        .in2         (in2),
        .out         (s_out),
        .carry       (s_carry),
        .out_valid   (s_out_valid),
        .clr_stats   (clr_stats),
        .op_count    (s_op_count),
        .carry_count (s_carry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        o;
        logic        c;
        logic [15:0] op;
        logic [15:0] cy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mop    = 0;
    int   mcy    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; eo/ec are the hand-computed result bits for this vector.
    task automatic step(input logic r, input logic v, input logic a, input logic b,
                        input logic clr, input logic eo, input logic ec);
        exp_t e;
        rst       = r;
        in_valid  = v;
        in1       = a;
        in2       = b;
        clr_stats = clr;
        if (r) begin
            mop = 0;
            mcy = 0;
        end else begin
            if (clr) begin
                mop = 0;
                mcy = 0;
            end else if (v) begin
                if (mop < 65535) mop++;
                if (ec && mcy < 65535) mcy++;
            end
            if (v) begin
                e.o  = eo;
                e.c  = ec;
                e.op = STATS ? 16'(mop) : 16'd0;
                e.cy = STATS ? 16'(mcy) : 16'd0;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented result is matched against the scoreboard.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("mon_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_out",         {31'd0, out},   {31'd0, e.o});
                chk("mon_carry",       {31'd0, carry}, {31'd0, e.c});
                chk("mon_op_count",    {16'd0, op_count},    {16'd0, e.op});
                chk("mon_carry_count", {16'd0, carry_count}, {16'd0, e.cy});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; in1 = 1'b1; in2 = 1'b1; clr_stats = 1'b0;

        // Reset with active operands
        step(1, 1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 0);
        chk("rst_out",         {31'd0, out},       0);
        chk("rst_carry",       {31'd0, carry},     0);
        chk("rst_out_valid",   {31'd0, out_valid}, 0);
        chk("rst_op_count",    {16'd0, op_count},    0);
        chk("rst_carry_count", {16'd0, carry_count}, 0);

        // Exhaustive truth table
        step(0, 1, 0, 0, 0, 0, 0);
        chk("tt00_out", {31'd0, out}, 0); chk("tt00_carry", {31'd0, carry}, 0);
        chk("tt00_vld", {31'd0, out_valid}, 1);
        step(0, 1, 0, 1, 0, 1, 0);
        chk("tt01_out", {31'd0, out}, 1); chk("tt01_carry", {31'd0, carry}, 0);
        chk("tt01_vld", {31'd0, out_valid}, 1);
        step(0, 1, 1, 0, 0, 1, 0);
        chk("tt10_out", {31'd0, out}, 1); chk("tt10_carry", {31'd0, carry}, 0);
        chk("tt10_vld", {31'd0, out_valid}, 1);
        step(0, 1, 1, 1, 0, 0, 1);
        chk("tt11_out", {31'd0, out}, 0); chk("tt11_carry", {31'd0, carry}, 1);
        chk("tt11_vld", {31'd0, out_valid}, 1);
        chk("tt_op_count",    {16'd0, op_count},    STATS ? 4 : 0);
        chk("tt_carry_count", {16'd0, carry_count}, STATS ? 1 : 0);

        // Idle hold after an accept of 11
        step(0, 1, 1, 1, 0, 0, 1);
        chk("hold_first_vld", {31'd0, out_valid}, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("hold1_vld", {31'd0, out_valid}, 0);
        chk("hold1_out", {31'd0, out}, 0); chk("hold1_carry", {31'd0, carry}, 1);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("hold2_vld", {31'd0, out_valid}, 0);
        chk("hold2_out", {31'd0, out}, 0); chk("hold2_carry", {31'd0, carry}, 1);
        step(0, 0, 1, 1, 0, 0, 0);
        chk("hold3_vld", {31'd0, out_valid}, 0);
        chk("hold3_out", {31'd0, out}, 0); chk("hold3_carry", {31'd0, carry}, 1);
        chk("pre_clr_op_count",    {16'd0, op_count},    STATS ? 5 : 0);
        chk("pre_clr_carry_count", {16'd0, carry_count}, STATS ? 2 : 0);

        // Clear colliding with an accept of 11
        step(0, 1, 1, 1, 1, 0, 1);
        chk("clr_op_count",    {16'd0, op_count},    0);
        chk("clr_carry_count", {16'd0, carry_count}, 0);
        chk("clr_out",   {31'd0, out},       0);
        chk("clr_carry", {31'd0, carry},     1);
        chk("clr_vld",   {31'd0, out_valid}, 1);

        // Saturation on the 2-bit counter instance
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0, 0, 1);
        chk("sat_op_count",    {30'd0, s_op_count},    STATS ? 3 : 0);
        chk("sat_carry_count", {30'd0, s_carry_count}, STATS ? 3 : 0);
        step(0, 1, 1, 1, 0, 0, 1);
        chk("sat_hold_op_count",    {30'd0, s_op_count},    STATS ? 3 : 0);
        chk("sat_hold_carry_count", {30'd0, s_carry_count}, STATS ? 3 : 0);
        chk("sat_main_op_count",    {16'd0, op_count},      STATS ? 7 : 0);

        // Mid-operation reset
        step(0, 1, 1, 0, 0, 1, 0);
        chk("mid_pre_out", {31'd0, out}, 1);
        step(1, 1, 1, 0, 0, 0, 0);
        chk("mid_rst_vld",   {31'd0, out_valid}, 0);
        chk("mid_rst_out",   {31'd0, out},       0);
        chk("mid_rst_carry", {31'd0, carry},     0);
        chk("mid_rst_op_count", {16'd0, op_count}, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_vld", {31'd0, out_valid}, 0);

        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
